// File: rtl/cfg_reg_bank_if.sv
// cfg_reg_bank_if: bus bundle for cfg_reg_bank; cfg_changed exists only when CFG_CHANGE_IRQ_EN is defined
interface cfg_reg_bank_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
);
  logic                       write;
  logic                       read;
  logic                       commit;
  logic                       lock;
  logic [DATA_W-1:0]          data_in;
  logic [ADDR_W-1:0]          address;
  logic [DATA_W-1:0]          data_out;
  logic                       rd_valid;
  logic                       wr_err;
  logic                       pending;
  logic [NUM_REGS*DATA_W-1:0] cfg_active;
`ifdef CFG_CHANGE_IRQ_EN
  logic [NUM_REGS-1:0]        cfg_changed;
  modport master (output write, read, commit, lock, data_in, address,
                  input data_out, rd_valid, wr_err, pending, cfg_active, cfg_changed);
  modport slave  (input write, read, commit, lock, data_in, address,
                  output data_out, rd_valid, wr_err, pending, cfg_active, cfg_changed);
`else
  modport master (output write, read, commit, lock, data_in, address,
                  input data_out, rd_valid, wr_err, pending, cfg_active);
  modport slave  (input write, read, commit, lock, data_in, address,
                  output data_out, rd_valid, wr_err, pending, cfg_active);
`endif
endinterface

// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: shadow/active configuration register bank with atomic commit, write-lock and error pulses.
// Optional CFG_CHANGE_IRQ_EN adds per-register cfg_changed pulses after each commit.
module cfg_reg_bank #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS =
    {16'h0001, 16'h0, 16'h0, 16'hABCD, 16'h0, 16'h0, 16'h0, 16'hFFFF},
  parameter logic [NUM_REGS*DATA_W-1:0] WR_MASKS = '1
) (
  input logic           clk,
  input logic           reset,
  cfg_reg_bank_if.slave bus
);
  logic [DATA_W-1:0] r_shadow [NUM_REGS];
  logic [DATA_W-1:0] r_active [NUM_REGS];
  logic [DATA_W-1:0] r_data_out;
  logic              r_rd_valid, r_wr_err, r_pending;
  logic              w_in_range, w_wr_ok;
  assign w_in_range = {1'b0, bus.address} < (ADDR_W+1)'(NUM_REGS);
  assign w_wr_ok    = bus.write && !bus.lock && w_in_range;
  // Active copies the pre-edge shadow, so a same-cycle write lands only in shadow and keeps pending set
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= RST_VALS[i*DATA_W +: DATA_W];
        r_active[i] <= RST_VALS[i*DATA_W +: DATA_W];
      end
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_wr_err   <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_ok && bus.address == ADDR_W'(i))
          r_shadow[i] <= (r_shadow[i] & ~WR_MASKS[i*DATA_W +: DATA_W]) |
                         (bus.data_in & WR_MASKS[i*DATA_W +: DATA_W]);
        if (bus.commit)
          r_active[i] <= r_shadow[i];
      end
      if (bus.read)
        r_data_out <= w_in_range ? r_shadow[bus.address] : '0;
      r_rd_valid <= bus.read;
      r_wr_err   <= bus.write && !w_wr_ok;
      r_pending  <= w_wr_ok || (r_pending && !bus.commit);
    end
  assign bus.data_out = r_data_out;
  assign bus.rd_valid = r_rd_valid;
  assign bus.wr_err   = r_wr_err;
  assign bus.pending  = r_pending;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign bus.cfg_active[g*DATA_W +: DATA_W] = r_active[g];
  end
`ifdef CFG_CHANGE_IRQ_EN
  logic [NUM_REGS-1:0] r_changed;
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      r_changed <= '0;
    else
      for (int i = 0; i < NUM_REGS; i++)
        r_changed[i] <= bus.commit && (r_shadow[i] != r_active[i]);
  assign bus.cfg_changed = r_changed;
`endif
endmodule

// File: tb/tb_cfg_reg_bank.sv
// tb_cfg_reg_bank: directed self-checking bench; d0 uses default parameters, d1 has 6 registers and a masked reg1.
module tb_cfg_reg_bank;
  localparam logic [127:0] RST0 = {16'h0001, 16'h0, 16'h0, 16'hABCD, 16'h0, 16'h0, 16'h0, 16'hFFFF};
  localparam logic [95:0]  RST1 = {16'h0, 16'hABCD, 16'h0, 16'h0, 16'h0, 16'hFFFF};
  localparam logic [95:0]  MSK1 = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h00FF, 16'hFFFF};
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  cfg_reg_bank_if #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3)) b0();
  cfg_reg_bank_if #(.DATA_W(16), .NUM_REGS(6), .ADDR_W(3)) b1();
  cfg_reg_bank #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .RST_VALS(RST0))
    d0 (.clk(clk), .reset(reset), .bus(b0.slave));
  cfg_reg_bank #(.DATA_W(16), .NUM_REGS(6), .ADDR_W(3), .RST_VALS(RST1), .WR_MASKS(MSK1))
    d1 (.clk(clk), .reset(reset), .bus(b1.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr0(input logic [2:0] a, input logic [15:0] d);
    b0.write = 1'b1; b0.address = a; b0.data_in = d;
    tick();
    b0.write = 1'b0;
  endtask

  task automatic rd0(input logic [2:0] a, output logic [15:0] d, output logic v);
    b0.read = 1'b1; b0.address = a;
    tick();
    b0.read = 1'b0;
    d = b0.data_out; v = b0.rd_valid;
  endtask

  task automatic cm0();
    b0.commit = 1'b1;
    tick();
    b0.commit = 1'b0;
  endtask

  task automatic wr1(input logic [2:0] a, input logic [15:0] d);
    b1.write = 1'b1; b1.address = a; b1.data_in = d;
    tick();
    b1.write = 1'b0;
  endtask

  task automatic rd1(input logic [2:0] a, output logic [15:0] d, output logic v);
    b1.read = 1'b1; b1.address = a;
    tick();
    b1.read = 1'b0;
    d = b1.data_out; v = b1.rd_valid;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (b0.data_out !== 16'h0) begin errors++; $display("FAIL rst_data_out got %h exp 0000", b0.data_out); end
    checks++; if (b0.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b exp 0", b0.rd_valid); end
    checks++; if (b0.wr_err !== 1'b0) begin errors++; $display("FAIL rst_wr_err got %b exp 0", b0.wr_err); end
    checks++; if (b0.pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b exp 0", b0.pending); end
    checks++; if (b0.cfg_active !== RST0) begin errors++; $display("FAIL rst_active0 got %h exp %h", b0.cfg_active, RST0); end
    checks++; if (b1.cfg_active !== RST1) begin errors++; $display("FAIL rst_active1 got %h exp %h", b1.cfg_active, RST1); end
`ifdef CFG_CHANGE_IRQ_EN
    checks++; if (b0.cfg_changed !== 8'h0) begin errors++; $display("FAIL rst_changed got %b exp 0", b0.cfg_changed); end
`endif
    reset = 1'b1;
    tick();
  endtask

  task automatic test_read_reset();
    logic [15:0] exp [8] = '{16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hABCD, 16'h0, 16'h0, 16'h0001};
    logic [15:0] d;
    logic v;
    for (int a = 0; a < 8; a++) begin
      rd0(3'(a), d, v);
      checks++; if (d !== exp[a]) begin errors++; $display("FAIL rd_reset[%0d] got %h exp %h", a, d, exp[a]); end
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL rd_reset_valid[%0d] got %b exp 1", a, v); end
    end
    tick();
    checks++; if (b0.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_idle_valid got %b exp 0", b0.rd_valid); end
    checks++; if (b0.data_out !== 16'h0001) begin errors++; $display("FAIL rd_hold got %h exp 0001", b0.data_out); end
  endtask

  task automatic test_shadow_commit();
    logic [15:0] d;
    logic v;
    b0.write = 1'b1; b0.data_in = 16'h0110;
    for (int a = 0; a < 8; a++) begin
      b0.address = 3'(a);
      tick();
    end
    b0.write = 1'b0;
    checks++; if (b0.cfg_active !== RST0) begin errors++; $display("FAIL sc_active_pre got %h exp %h", b0.cfg_active, RST0); end
    checks++; if (b0.pending !== 1'b1) begin errors++; $display("FAIL sc_pending_pre got %b exp 1", b0.pending); end
    for (int a = 0; a < 8; a++) begin
      rd0(3'(a), d, v);
      checks++; if (d !== 16'h0110) begin errors++; $display("FAIL sc_read[%0d] got %h exp 0110", a, d); end
    end
    cm0();
    checks++; if (b0.cfg_active !== {8{16'h0110}}) begin errors++; $display("FAIL sc_active_post got %h exp all 0110", b0.cfg_active); end
    checks++; if (b0.pending !== 1'b0) begin errors++; $display("FAIL sc_pending_post got %b exp 0", b0.pending); end
  endtask

  task automatic test_walking();
    logic [15:0] p, d;
    logic v;
    for (int k = 0; k < 18; k++) begin
      p = (k < 16) ? 16'h1 << k : (k == 16) ? 16'hFFFF : 16'h0000;
      wr0(3'd3, p);
      cm0();
      rd0(3'd3, d, v);
      checks++; if (b0.cfg_active[63:48] !== p) begin errors++; $display("FAIL walk_active[%0d] got %h exp %h", k, b0.cfg_active[63:48], p); end
      checks++; if (d !== p) begin errors++; $display("FAIL walk_read[%0d] got %h exp %h", k, d, p); end
    end
  endtask

  task automatic test_commit_write();
    logic [15:0] d;
    logic v;
    b0.write = 1'b1; b0.address = 3'd0; b0.data_in = 16'h1111; b0.commit = 1'b1;
    tick();
    b0.write = 1'b0; b0.commit = 1'b0;
    checks++; if (b0.cfg_active[15:0] !== 16'h0110) begin errors++; $display("FAIL cw_active got %h exp 0110", b0.cfg_active[15:0]); end
    checks++; if (b0.pending !== 1'b1) begin errors++; $display("FAIL cw_pending got %b exp 1", b0.pending); end
    rd0(3'd0, d, v);
    checks++; if (d !== 16'h1111) begin errors++; $display("FAIL cw_read got %h exp 1111", d); end
    cm0();
    checks++; if (b0.cfg_active[15:0] !== 16'h1111) begin errors++; $display("FAIL cw_active2 got %h exp 1111", b0.cfg_active[15:0]); end
    checks++; if (b0.pending !== 1'b0) begin errors++; $display("FAIL cw_pending2 got %b exp 0", b0.pending); end
  endtask

  task automatic test_mask_lock();
    logic [15:0] d;
    logic v;
    wr1(3'd1, 16'hFFFF);
    rd1(3'd1, d, v);
    checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL mask_read got %h exp 00FF", d); end
    b1.lock = 1'b1;
    wr1(3'd2, 16'h1234);
    checks++; if (b1.wr_err !== 1'b1) begin errors++; $display("FAIL lock_err got %b exp 1", b1.wr_err); end
    tick();
    checks++; if (b1.wr_err !== 1'b0) begin errors++; $display("FAIL lock_err_clr got %b exp 0", b1.wr_err); end
    rd1(3'd2, d, v);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL lock_read got %h exp 0000", d); end
    b1.commit = 1'b1;
    tick();
    b1.commit = 1'b0;
    checks++; if (b1.cfg_active[31:16] !== 16'h00FF) begin errors++; $display("FAIL lock_commit got %h exp 00FF", b1.cfg_active[31:16]); end
    checks++; if (b1.pending !== 1'b0) begin errors++; $display("FAIL lock_pending got %b exp 0", b1.pending); end
    b1.lock = 1'b0;
  endtask

  task automatic test_range();
    logic [15:0] d;
    logic v;
    wr1(3'd7, 16'hAAAA);
    checks++; if (b1.wr_err !== 1'b1) begin errors++; $display("FAIL range_err got %b exp 1", b1.wr_err); end
    checks++; if (b1.pending !== 1'b0) begin errors++; $display("FAIL range_pending got %b exp 0", b1.pending); end
    rd1(3'd7, d, v);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL range_read got %h exp 0000", d); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL range_valid got %b exp 1", v); end
    checks++; if (b1.wr_err !== 1'b0) begin errors++; $display("FAIL range_err_clr got %b exp 0", b1.wr_err); end
  endtask

  task automatic test_rdw();
    logic [15:0] d;
    logic v;
    b1.write = 1'b1; b1.read = 1'b1; b1.address = 3'd0; b1.data_in = 16'h5555;
    tick();
    b1.write = 1'b0; b1.read = 1'b0;
    checks++; if (b1.data_out !== 16'hFFFF) begin errors++; $display("FAIL rdw_old got %h exp FFFF", b1.data_out); end
    rd1(3'd0, d, v);
    checks++; if (d !== 16'h5555) begin errors++; $display("FAIL rdw_new got %h exp 5555", d); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] d;
    logic v;
    wr0(3'd5, 16'h7777);
    #2 reset = 1'b0;
    #1;
    checks++; if (b0.cfg_active !== RST0) begin errors++; $display("FAIL mr_active0 got %h exp %h", b0.cfg_active, RST0); end
    checks++; if (b1.cfg_active !== RST1) begin errors++; $display("FAIL mr_active1 got %h exp %h", b1.cfg_active, RST1); end
    checks++; if (b0.pending !== 1'b0) begin errors++; $display("FAIL mr_pending got %b exp 0", b0.pending); end
    tick();
    reset = 1'b1;
    tick();
    rd0(3'd5, d, v);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mr_read5 got %h exp 0000", d); end
    rd0(3'd0, d, v);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL mr_read0 got %h exp FFFF", d); end
    rd1(3'd0, d, v);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL mr_read1_0 got %h exp FFFF", d); end
    rd1(3'd1, d, v);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL mr_read1_1 got %h exp 0000", d); end
  endtask

`ifdef CFG_CHANGE_IRQ_EN
  task automatic test_irq();
    wr0(3'd4, 16'hABCD);
    wr0(3'd5, 16'h0042);
    cm0();
    checks++; if (b0.cfg_changed !== 8'b0010_0000) begin errors++; $display("FAIL irq_pulse got %b exp 00100000", b0.cfg_changed); end
    tick();
    checks++; if (b0.cfg_changed !== 8'b0) begin errors++; $display("FAIL irq_clear got %b exp 00000000", b0.cfg_changed); end
  endtask
`endif

  initial begin
    b0.write = 1'b0; b0.read = 1'b0; b0.commit = 1'b0; b0.lock = 1'b0; b0.data_in = '0; b0.address = '0;
    b1.write = 1'b0; b1.read = 1'b0; b1.commit = 1'b0; b1.lock = 1'b0; b1.data_in = '0; b1.address = '0;
    test_reset();
    test_read_reset();
    test_shadow_commit();
    test_walking();
    test_commit_write();
    test_mask_lock();
    test_range();
    test_rdw();
    test_mid_reset();
`ifdef CFG_CHANGE_IRQ_EN
    test_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cfg_reg_bank.md
Name: cfg_reg_bank

Overview:
- Parametrised successor to the fixed 8 x 16-bit configuration register file.
- Width, depth, per-register reset values and per-bit write masks are parameters.
- Writes land in a shadow bank; a commit pulse copies the whole shadow bank to the active bank atomically, so downstream analog/digital blocks never see a half-updated configuration.
- Adds registered read with a valid strobe, write-lock, and out-of-range/locked-write error reporting.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of registers (1..2**ADDR_W).
- ADDR_W, 3, address width.
- RST_VALS, {16'h0001,16'h0,16'h0,16'hABCD,16'h0,16'h0,16'h0,16'hFFFF}, packed NUM_REGS*DATA_W vector; register i reset value = RST_VALS[i*DATA_W +: DATA_W] (reg0=FFFF, reg4=ABCD, reg7=0001).
- WR_MASKS, all ones, packed NUM_REGS*DATA_W vector; 1 = bit writable, 0 = bit read-only (holds its reset value).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- write  in  1  write strobe, sampled on rising clk.
- data_in  in  DATA_W  write data.
- address  in  ADDR_W  register index for read and write.
- read  in  1  read strobe.
- commit  in  1  copy shadow bank to active bank.
- lock  in  1  level; when 1, writes are rejected.
- data_out  out  DATA_W  registered read data (shadow bank).
- rd_valid  out  1  one-cycle pulse, data_out valid.
- wr_err  out  1  one-cycle pulse on a rejected write.
- pending  out  1  shadow differs from active (an uncommitted write exists).
- cfg_active  out  NUM_REGS*DATA_W  flattened active bank driving downstream logic.

Behaviour:
- Reset (reset=0, asynchronous):
  - shadow and active banks = RST_VALS.
  - data_out=0, rd_valid=0, wr_err=0, pending=0.
  - Reset asserted mid-operation discards all uncommitted writes.
- Write: on a rising edge with write=1, lock=0 and address<NUM_REGS:
  - shadow[a] <= (shadow[a] & ~mask[a]) | (data_in & mask[a]).
  - pending <= 1.
  - Accepted even if the masked value is unchanged.
- Rejected write: write=1 with lock=1 or address>=NUM_REGS leaves state unchanged. wr_err=1 on the next cycle for exactly 1 cycle.
- Read: read=1 at edge N gives data_out = shadow[address] and rd_valid=1 after edge N.
  - Latency is 1 cycle.
  - Out-of-range address returns 0 with rd_valid=1.
  - data_out holds its value when read=0; rd_valid=0.
- Read and write to the same address in the same cycle: read-before-write. data_out shows the old value; the new value is visible on a read the following cycle.
- Commit: on a rising edge with commit=1, every active[i] <= shadow[i] and pending <= 0.
  - Commit is allowed while lock=1.
- Commit and accepted write in the same cycle:
  - active takes the pre-write shadow.
  - The write updates shadow.
  - pending stays 1.
- Back-to-back writes at full rate (every cycle) are supported.
- Read-only mask bits never change from reset in either bank.
- No internal FSM beyond the commit/pending flag. All outputs are registered.

Optional Feature:
- Macro: CFG_CHANGE_IRQ_EN.
- Defined:
  - Adds output cfg_changed [NUM_REGS-1:0].
  - One cycle after a commit edge, bit i pulses high for one cycle iff active[i] changed value on that commit.
  - Reset value 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then read addresses 0..7 -> data_out FFFF,0000,0000,0000,ABCD,0000,0000,0001, each with rd_valid one cycle after read; cfg_active equals RST_VALS.
- Write 0110 to all 8 addresses, no commit -> reads return 0110, cfg_active unchanged, pending=1. Pulse commit -> cfg_active all 0110, pending=0.
- Walking ones: write 0001<<k to reg3 for k=0..15, commit and read after each -> active and readback equal 0001<<k. Repeat with FFFF then 0000 for 0->1 and 1->0 transitions on all bits.
- WR_MASKS reg1=00FF: write FFFF -> readback 00FF. Set lock=1, write reg2=1234 -> wr_err pulse, reg2 still 0000.
- NUM_REGS=6, write address 7 -> wr_err pulse, read address 7 -> 0000. Same-cycle write 5555/read reg0 -> old FFFF, next read 5555. Assert reset mid-sequence -> all values back to RST_VALS.
- With CFG_CHANGE_IRQ_EN: write reg4=ABCD (unchanged) and reg5=0042, commit -> cfg_changed=8'b0010_0000 for one cycle. Same cycle commit+write reg0=1111 -> active reg0 keeps old shadow, pending stays 1.
